// File: rtl/dec_pkg.sv
// Shared decode constants and the decoded-control bundle for the instruction
// decode queue.
package dec_pkg;

    localparam logic [3:0] SRC_IMM    = 4'd8;
    localparam logic [3:0] SRC_IPIN   = 4'd9;
    localparam logic [3:0] SRC_NONE   = 4'd10;
    localparam int         ALU_EN_IDX = 8;

    // Opcode prefixes, matched against the top bits of the issue register
    localparam logic       OPC_LOAD = 1'b0;
    localparam logic [1:0] OPC_MOV  = 2'b10;
    localparam logic [2:0] OPC_ALU  = 3'b110;
    localparam logic [3:0] OPC_JMP  = 4'b1110;
    localparam logic [3:0] OPC_JNZ  = 4'b1111;

    localparam logic [2:0] I_DST = 3'd6;

    typedef struct packed {
        logic [8:0] reg_en;
        logic [3:0] source_sel;
        logic       i_sel;
        logic       x_sel;
        logic       y_sel;
        logic       jmp;
        logic       jmp_nz;
    } dec_ctrl_t;

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous FIFO with synchronous clear; clear also serves as
// the reset of the pointers and occupancy count.
module instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers are exactly log2(DEPTH) wide, so they wrap for free
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_decode_queue.sv
// Queued instruction issue and decode stage between fetch and the datapath.
// Optional statistics counters are built only when DEC_STATS_EN is defined.
module instr_decode_queue
    import dec_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef DEC_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_instr,
    output logic                     in_ready,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [7:0]               ir,
    output logic [$clog2(DEPTH):0]   level,
    output logic [8:0]               reg_en,
    output logic [3:0]               source_sel,
    output logic [3:0]               imm,
    output logic                     i_sel,
    output logic                     x_sel,
    output logic                     y_sel,
    output logic [2:0]               alu_op,
    output logic                     jmp,
    output logic                     jmp_nz
`ifdef DEC_STATS_EN
    , output logic [CNT_W-1:0]       issued_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             out_valid_q, out_valid_d;
    logic [7:0]       ir_q, ir_d;
    logic             fifo_push, fifo_pop, fifo_clear;
    logic [7:0]       fifo_head;
    logic [LVL_W-1:0] fifo_count;
    logic             accept, slot_free, auto_flush;
    dec_ctrl_t        ctrl;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (in_instr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign in_ready   = !sync_reset && !flush && (fifo_count < LVL_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign slot_free  = !out_valid_q || out_ready;
    assign auto_flush = out_valid_q && out_ready && ctrl.jmp;

    always_comb begin
        out_valid_d = out_valid_q;
        ir_d        = ir_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_clear  = 1'b0;
        if (sync_reset || flush || auto_flush) begin
            fifo_clear  = 1'b1;
            out_valid_d = 1'b0;
        end else if (slot_free) begin
            if (fifo_count != '0) begin
                ir_d        = fifo_head;
                out_valid_d = 1'b1;
                fifo_pop    = 1'b1;
                fifo_push   = accept;
            end else if (accept) begin
                // Empty queue: bypass straight into the issue register
                ir_d        = in_instr;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            fifo_push = accept;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            out_valid_q <= 1'b0;
            ir_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ir_q        <= ir_d;
        end
    end

    always_comb begin
        ctrl            = '0;
        ctrl.source_sel = SRC_NONE;
        ctrl.i_sel      = 1'b1;
        if (out_valid_q) begin
            if (ir_q[7] == OPC_LOAD) begin
                ctrl.reg_en[ir_q[6:4]] = 1'b1;
                ctrl.source_sel        = SRC_IMM;
                ctrl.i_sel             = (ir_q[6:4] != I_DST);
            end else if (ir_q[7:6] == OPC_MOV) begin
                ctrl.reg_en[ir_q[5:3]] = 1'b1;
                // Self-move selects the input pin instead of the register
                ctrl.source_sel = (ir_q[5:3] == ir_q[2:0]) ? SRC_IPIN : {1'b0, ir_q[2:0]};
                ctrl.i_sel      = (ir_q[5:3] != I_DST);
            end else if (ir_q[7:5] == OPC_ALU) begin
                ctrl.reg_en[ALU_EN_IDX] = 1'b1;
                ctrl.x_sel              = ir_q[4];
                ctrl.y_sel              = ir_q[3];
            end else if (ir_q[7:4] == OPC_JMP) begin
                ctrl.jmp = 1'b1;
            end else if (ir_q[7:4] == OPC_JNZ) begin
                ctrl.jmp_nz = 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign ir         = ir_q;
    assign level      = fifo_count;
    assign reg_en     = ctrl.reg_en;
    assign source_sel = ctrl.source_sel;
    assign imm        = ir_q[3:0];
    assign i_sel      = ctrl.i_sel;
    assign x_sel      = ctrl.x_sel;
    assign y_sel      = ctrl.y_sel;
    assign alu_op     = ir_q[2:0];
    assign jmp        = ctrl.jmp;
    assign jmp_nz     = ctrl.jmp_nz;

`ifdef DEC_STATS_EN
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issued_cnt_d = issued_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (out_valid_q && out_ready && (issued_cnt_q != '1)) begin
            issued_cnt_d = issued_cnt_q + 1'b1;
        end
        if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: directed cases followed by random
// traffic, checked against a queue-level reference model.
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef DEC_STATS_EN
    localparam int CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             sync_reset, in_valid, out_ready, flush;
    logic [7:0]       in_instr;
    logic             in_ready, out_valid;
    logic [7:0]       ir;
    logic [LVL_W-1:0] level;
    logic [8:0]       reg_en;
    logic [3:0]       source_sel, imm;
    logic             i_sel, x_sel, y_sel, jmp, jmp_nz;
    logic [2:0]       alu_op;
`ifdef DEC_STATS_EN
    logic [CNT_W-1:0] issued_cnt, stall_cnt;
`endif

    instr_decode_queue #(
        .DEPTH (DEPTH)
`ifdef DEC_STATS_EN
        , .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .ir         (ir),
        .level      (level),
        .reg_en     (reg_en),
        .source_sel (source_sel),
        .imm        (imm),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .alu_op     (alu_op),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz)
`ifdef DEC_STATS_EN
        , .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         live = 0;
    int         exp_issued = 0;
    int         exp_stall  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Decode reference written from the opcode map with plain arithmetic
    function automatic logic [17:0] ref_dec(input logic [7:0] i, input bit v);
        int n, d, s, src;
        logic [8:0] re;
        bit isel, x, y, j, jn;
        n = int'(i); re = '0; src = 10; isel = 1; x = 0; y = 0; j = 0; jn = 0;
        if (v) begin
            if (n < 128) begin
                d = n / 16; re[d] = 1'b1; src = 8; isel = (d != 6);
            end else if (n < 192) begin
                d = (n / 8) % 8; s = n % 8; re[d] = 1'b1;
                src = (d == s) ? 9 : s; isel = (d != 6);
            end else if (n < 224) begin
                re[8] = 1'b1; x = ((n / 16) % 2) == 1; y = ((n / 8) % 2) == 1;
            end else if (n < 240) begin
                j = 1;
            end else begin
                jn = 1;
            end
        end
        return {re, 4'(src), isel, x, y, j, jn};
    endfunction

    // Reference model: exp_q holds every instruction in flight, head = issue register
    initial forever begin
        int lvl;
        bit acc;
        @(posedge clk);
        lvl = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
        acc = in_valid && !sync_reset && !flush && (lvl < DEPTH);
        if (sync_reset) begin
            exp_q.delete();
            exp_issued = 0;
            exp_stall  = 0;
        end else begin
            if (exp_q.size() > 0) begin
                if (out_ready) exp_issued++;
                else           exp_stall++;
            end
            if (flush) begin
                exp_q.delete();
            end else if (exp_q.size() > 0 && out_ready && exp_q[0][7:4] == 4'hE) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(in_instr);
            end
        end
        live = 1;
    end

    // Monitor: compares DUT outputs against the model every falling edge
    initial forever begin
        int sz, lvl;
        bit ev;
        @(negedge clk);
        if (live) begin
            sz  = exp_q.size();
            ev  = (sz > 0);
            lvl = ev ? sz - 1 : 0;
            check("out_valid", 32'(out_valid), 32'(ev));
            check("level", 32'(level), 32'(lvl));
            check("in_ready", 32'(in_ready), 32'(!sync_reset && !flush && (lvl < DEPTH)));
            if (ev) begin
                check("ir", 32'(ir), 32'(exp_q[0]));
                check("imm", 32'(imm), 32'(exp_q[0] % 16));
                check("alu_op", 32'(alu_op), 32'(exp_q[0] % 8));
            end
            check("decode", 32'({reg_en, source_sel, i_sel, x_sel, y_sel, jmp, jmp_nz}),
                  32'(ref_dec(ev ? exp_q[0] : 8'h00, ev)));
`ifdef DEC_STATS_EN
            check("issued_cnt", 32'(issued_cnt), 32'(exp_issued));
            check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        sync_reset = 1; in_valid = 0; in_instr = '0; out_ready = 0; flush = 0;
        repeat (3) step();
        check("reset_level", 32'(level), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        sync_reset = 0;

        // Bypass into an empty queue
        out_ready = 1; in_valid = 1; in_instr = 8'h35;
        step();
        in_valid = 0;
        check("bypass_valid", 32'(out_valid), 32'd1);
        check("bypass_reg_en", 32'(reg_en), 32'h008);
        check("bypass_src", 32'(source_sel), 32'd8);
        check("bypass_imm", 32'(imm), 32'd5);
        check("bypass_level", 32'(level), 32'd0);
        step();

        // Fill to DEPTH behind a stalled issue register, then drain in order
        out_ready = 0;
        for (int k = 0; k <= DEPTH; k++) begin
            in_valid = 1; in_instr = 8'(8'h10 + k);
            step();
        end
        in_valid = 0;
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1;
        for (int k = 0; k <= DEPTH; k++) begin
            check("drain_ir", 32'(ir), 32'(8'h10 + k));
            step();
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // MOV decode corner cases
        out_ready = 0; in_valid = 1; in_instr = 8'h9B;
        step();
        check("mov_self_reg_en", 32'(reg_en), 32'h008);
        check("mov_self_src", 32'(source_sel), 32'd9);
        out_ready = 1; in_instr = 8'hB1;
        step();
        in_valid = 0; out_ready = 0;
        check("mov_d6_reg_en", 32'(reg_en), 32'h040);
        check("mov_d6_src", 32'(source_sel), 32'd1);
        check("mov_d6_i_sel", 32'(i_sel), 32'd0);
        out_ready = 1;
        step();

        // JMP auto-flush drops queued and concurrent instructions
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_instr = (k == 0) ? 8'hE4 : 8'(k);
            step();
        end
        in_valid = 0;
        check("jmp_pre_level", 32'(level), 32'd3);
        out_ready = 1; in_valid = 1; in_instr = 8'h55;
        step();
        in_valid = 0;
        check("jmp_level", 32'(level), 32'd0);
        check("jmp_valid", 32'(out_valid), 32'd0);

        // External flush
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_instr = 8'(8'h21 + k);
            step();
        end
        in_valid = 0;
        check("flush_pre_level", 32'(level), 32'd2);
        flush = 1;
        step();
        flush = 0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_reg_en", 32'(reg_en), 32'd0);
        check("flush_src", 32'(source_sel), 32'd10);

`ifdef DEC_STATS_EN
        sync_reset = 1;
        step();
        sync_reset = 0;
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            in_instr = 8'(8'h20 + k);
            step();
        end
        in_valid = 0; out_ready = 0;
        repeat (3) step();
        out_ready = 1;
        step();
        check("stats_issued", 32'(issued_cnt), 32'd5);
        check("stats_stall", 32'(stall_cnt), 32'd3);
        sync_reset = 1;
        step();
        sync_reset = 0;
        check("stats_rst_issued", 32'(issued_cnt), 32'd0);
        check("stats_rst_stall", 32'(stall_cnt), 32'd0);
`endif

        // Random traffic
        repeat (3000) begin
            sync_reset = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            in_instr   = 8'($urandom);
            step();
        end
        sync_reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (DEPTH + 2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
